keccak_reg_initiator: RTL and testbench

KECCAK_REG_INITIATOR -- requirements
Module: keccak_reg_initiator

---
 rtl/keccak_x_heep_pkg.sv | 16 +
 rtl/reg_pkg.sv | 18 +
 rtl/keccak_reg_initiator_if.sv | 43 ++++
 rtl/keccak_reg_initiator.sv | 184 ++++++++++++++++++
 tb/tb_keccak_reg_initiator.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_x_heep_pkg.sv
// Shared constants and FSM state type for the keccak register-bus initiator.
package keccak_x_heep_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned WORD_BYTES      = WORD_W / 8;
  localparam int unsigned MAX_LEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    REQ,
    RD_OUT,
    DONE
  } init_state_e;

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by initiators and targets.
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/keccak_reg_initiator_if.sv
// Bundles the command, data-stream, status and register-bus signals of keccak_reg_initiator.
interface keccak_reg_initiator_if
  import keccak_x_heep_pkg::*;
#(
  parameter int unsigned LEN_W = $clog2(MAX_LEN_DEFAULT) + 1
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [WORD_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [WORD_W-1:0] rd_data;

  logic              busy;
  logic              done;
  logic              err;

  reg_pkg::reg_req_t reg_req;
  reg_pkg::reg_rsp_t reg_rsp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, reg_rsp,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done, err, reg_req
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, reg_rsp,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done, err, reg_req
  );

endinterface

// File: rtl/keccak_reg_initiator.sv
// Burst initiator: turns one command plus write/read streams into single-word register-bus accesses.
// Optional register-bus watchdog is enabled by defining KECCAK_REG_INITIATOR_TIMEOUT_EN.
module keccak_reg_initiator
  import keccak_x_heep_pkg::*;
#(
  parameter int unsigned  MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int unsigned  TIMEOUT_CYCLES = 256,
  localparam int unsigned LEN_W          = $clog2(MAX_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [WORD_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [WORD_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output reg_pkg::reg_req_t reg_req_o,
  input  reg_pkg::reg_rsp_t reg_rsp_i
);

  init_state_e       r_state;
  init_state_e       w_state_nxt;
  logic [WORD_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_write;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_err;

  logic w_accept;
  logic w_wr_hs;
  logic w_bus_ok;
  logic w_bus_err;
  logic w_rd_hs;
  logic w_last;
  logic w_timeout;

  assign w_accept  = (r_state == IDLE) && cmd_valid_i;
  assign w_wr_hs   = (r_state == WR_WAIT) && wr_valid_i;
  assign w_bus_ok  = (r_state == REQ) && reg_rsp_i.ready && !reg_rsp_i.error;
  assign w_bus_err = (r_state == REQ) && reg_rsp_i.ready && reg_rsp_i.error;
  assign w_rd_hs   = (r_state == RD_OUT) && rd_ready_i;
  assign w_last    = (r_cnt == LEN_W'(1));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: next state defaults to the current one first, so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_len_i == '0) begin
            w_state_nxt = DONE;
          end else if (cmd_write_i) begin
            w_state_nxt = WR_WAIT;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      WR_WAIT: begin
        if (wr_valid_i) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_bus_err || w_timeout) begin
          w_state_nxt = DONE;
        end else if (w_bus_ok) begin
          if (!r_write) begin
            w_state_nxt = RD_OUT;
          end else if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WR_WAIT;
          end
        end
      end
      RD_OUT: begin
        if (rd_ready_i) begin
          w_state_nxt = w_last ? DONE : REQ;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: data registers are reset too, so a reset mid-burst leaves no stale word to replay or expose.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= cmd_addr_i;
        r_cnt   <= cmd_len_i;
        r_write <= cmd_write_i;
        r_err   <= 1'b0;
      end
      if (w_wr_hs) begin
        r_wdata <= wr_data_i;
      end
      if (w_bus_ok && !r_write) begin
        r_rd_data <= reg_rsp_i.rdata;
      end
      // Address and count advance once a word has fully left the initiator.
      if ((w_bus_ok && r_write) || w_rd_hs) begin
        r_addr <= r_addr + WORD_W'(WORD_BYTES);
        r_cnt  <= r_cnt - LEN_W'(1);
      end
      if (w_bus_err || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef KECCAK_REG_INITIATOR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;

  // Counts consecutive REQ cycles without a response; restarts for every new request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if ((r_state == REQ) && !reg_rsp_i.ready) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == REQ) && !reg_rsp_i.ready &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;

  // The watchdog limit only matters when the timeout option is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog_limit
  end
`endif

  assign cmd_ready_o = (r_state == IDLE);
  assign wr_ready_o  = (r_state == WR_WAIT);
  assign rd_valid_o  = (r_state == RD_OUT);
  assign rd_data_o   = r_rd_data;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign err_o       = r_err;

  always_comb begin
    reg_req_o = '0;
    if (r_state == REQ) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = r_addr;
      reg_req_o.write = r_write;
      reg_req_o.wdata = r_wdata;
      reg_req_o.wstrb = 4'hF;
    end
  end

endmodule

// File: tb/tb_keccak_reg_initiator.sv
// Self-checking bench for keccak_reg_initiator: directed and random bursts against a word-level model.
// Build with KECCAK_REG_INITIATOR_TIMEOUT_EN defined to exercise the watchdog (limit 16 cycles).
module tb_keccak_reg_initiator;
  import keccak_x_heep_pkg::*;

  localparam int unsigned LEN_W  = $clog2(MAX_LEN_DEFAULT) + 1;
  localparam int          BUDGET = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keccak_reg_initiator_if #(.LEN_W(LEN_W)) bus ();

  keccak_reg_initiator #(
    .MAX_LEN       (MAX_LEN_DEFAULT),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(bus.cmd_valid),
    .cmd_ready_o(bus.cmd_ready),
    .cmd_write_i(bus.cmd_write),
    .cmd_addr_i (bus.cmd_addr),
    .cmd_len_i  (bus.cmd_len),
    .wr_valid_i (bus.wr_valid),
    .wr_ready_o (bus.wr_ready),
    .wr_data_i  (bus.wr_data),
    .rd_valid_o (bus.rd_valid),
    .rd_ready_i (bus.rd_ready),
    .rd_data_o  (bus.rd_data),
    .busy_o     (bus.busy),
    .done_o     (bus.done),
    .err_o      (bus.err),
    .reg_req_o  (bus.reg_req),
    .reg_rsp_i  (bus.reg_rsp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Responder configuration (written by the stimulus) and transaction log (written by the responder).
  int          rsp_lat   = 0;
  bit          rsp_never = 1'b0;
  int          err_at    = -1;
  int          stab_err  = 0;
  logic [31:0] obs_addr[$];
  logic        obs_write[$];
  logic [31:0] obs_wdata[$];

  int                rsp_wait = 0;
  bit                rsp_have_prev = 1'b0;
  reg_pkg::reg_req_t rsp_prev;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register target: answers after rsp_lat waiting cycles, flags an error on the err_at-th transaction.
  always @(negedge clk) begin
    bus.reg_rsp = '0;
    if (!rst_n || !bus.reg_req.valid) begin
      rsp_wait      = 0;
      rsp_have_prev = 1'b0;
    end else begin
      if (rsp_have_prev && (bus.reg_req !== rsp_prev)) stab_err++;
      rsp_prev      = bus.reg_req;
      rsp_have_prev = 1'b1;
      if (!rsp_never && (rsp_wait >= rsp_lat)) begin
        bus.reg_rsp.ready = 1'b1;
        bus.reg_rsp.error = (obs_addr.size() == err_at);
        bus.reg_rsp.rdata = bus.reg_rsp.error ? 32'hDEAD_BEEF : mem_word(bus.reg_req.addr);
        obs_addr.push_back(bus.reg_req.addr);
        obs_write.push_back(bus.reg_req.write);
        obs_wdata.push_back(bus.reg_req.wdata);
        rsp_wait      = 0;
        rsp_have_prev = 1'b0;
      end else begin
        rsp_wait++;
      end
    end
  end

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input int len);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LEN_W'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // One burst; err_k is the index of the word answered with an error (>= len for none).
  task automatic run_burst(input string tag, input bit wr, input logic [31:0] addr, input int len,
                           input int lat, input int stall, input int err_k);
    logic [31:0] data[$];
    logic [31:0] rd_seen[$];
    logic [31:0] last_rd;
    int base, stab0, wi, hold, cyc, exp_tx, exp_rd, viol_stab, viol_overlap;
    bit held, exp_err;
    for (int i = 0; i < len; i++) data.push_back($urandom);
    exp_err = (err_k < len);
    exp_tx  = exp_err ? err_k + 1 : len;
    exp_rd  = wr ? 0 : (exp_err ? err_k : len);
    base    = obs_addr.size();
    stab0   = stab_err;
    rsp_lat = lat;
    rsp_never = 1'b0;
    err_at  = base + err_k;
    wi = 0; hold = 0; held = 1'b0; viol_stab = 0; viol_overlap = 0; last_rd = '0;
    issue_cmd(wr, addr, len);
    check({tag, ":err_clr_on_accept"}, bus.err, 0);
    check({tag, ":busy"}, bus.busy, 1);
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      if (bus.done) break;
      if (bus.rd_valid && bus.reg_req.valid) viol_overlap++;
      if (bus.rd_valid) begin
        if (held && (bus.rd_data !== last_rd)) viol_stab++;
        bus.rd_ready = (hold >= stall);
        if (bus.rd_ready) begin
          rd_seen.push_back(bus.rd_data);
          hold = 0;
          held = 1'b0;
        end else begin
          hold++;
          held    = 1'b1;
          last_rd = bus.rd_data;
        end
      end else begin
        bus.rd_ready = 1'($urandom_range(0, 1));
        held = 1'b0;
      end
      if (wr && (wi < len)) begin
        bus.wr_valid = ($urandom_range(0, 3) != 0);
        bus.wr_data  = data[wi];
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = $urandom;
      end
      if (bus.wr_ready && bus.wr_valid) wi++;
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check({tag, ":done_within_budget"}, 32'(cyc < BUDGET), 1);
    check({tag, ":err_at_done"}, bus.err, 32'(exp_err));
    @(negedge clk);
    check({tag, ":done_one_pulse"}, bus.done, 0);
    check({tag, ":back_to_idle"}, bus.cmd_ready, 1);
    check({tag, ":err_sticky"}, bus.err, 32'(exp_err));
    check({tag, ":n_tx"}, obs_addr.size() - base, exp_tx);
    for (int i = 0; (i < exp_tx) && (base + i < obs_addr.size()); i++) begin
      check($sformatf("%s:addr%0d", tag, i), obs_addr[base+i], addr + 32'(4 * i));
      check($sformatf("%s:dir%0d", tag, i), obs_write[base+i], 32'(wr));
      if (wr) check($sformatf("%s:wdata%0d", tag, i), obs_wdata[base+i], data[i]);
    end
    check({tag, ":wr_words_taken"}, wi, wr ? exp_tx : 0);
    check({tag, ":n_rd"}, rd_seen.size(), exp_rd);
    for (int i = 0; (i < exp_rd) && (i < rd_seen.size()); i++) begin
      check($sformatf("%s:rdata%0d", tag, i), rd_seen[i], mem_word(addr + 32'(4 * i)));
    end
    check({tag, ":req_stable"}, stab_err - stab0, 0);
    check({tag, ":rd_held"}, viol_stab, 0);
    check({tag, ":no_req_in_rd_out"}, viol_overlap, 0);
  endtask

  initial begin
    int          base, n_valid, k;
    bit          r_wr;
    logic [31:0] r_addr;
    int          r_len, r_lat, r_stall, r_ek;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:cmd_ready", bus.cmd_ready, 1);
    check("rst:busy", bus.busy, 0);
    check("rst:done", bus.done, 0);
    check("rst:err", bus.err, 0);
    check("rst:rd_valid", bus.rd_valid, 0);
    check("rst:wr_ready", bus.wr_ready, 0);
    check("rst:rd_data", bus.rd_data, 0);
    check("rst:req_zero", 32'(bus.reg_req == '0), 1);
    rst_n = 1'b1;

    run_burst("wr3", 1'b1, 32'h0000_0000, 3, 2, 0, 99);
    run_burst("rd2_stall", 1'b0, 32'h0000_0100, 2, 1, 5, 99);
    run_burst("rd4_err", 1'b0, 32'h0000_0040, 4, 0, 1, 1);
    repeat (3) @(negedge clk);
    check("err_still_sticky", bus.err, 1);

    // Zero-length command: done_o in the cycle after the accepting edge, no bus access.
    base = obs_addr.size();
    issue_cmd(1'b1, 32'h0000_0080, 0);
    check("len0:done", bus.done, 1);
    check("len0:err_cleared", bus.err, 0);
    check("len0:no_valid", bus.reg_req.valid, 0);
    @(negedge clk);
    check("len0:done_low", bus.done, 0);
    check("len0:idle", bus.cmd_ready, 1);
    check("len0:no_tx", obs_addr.size() - base, 0);

    run_burst("wrap", 1'b1, 32'hFFFF_FFFC, 2, 1, 0, 99);

    // Reset while a request is waiting on the bus.
    rsp_never = 1'b1;
    base      = obs_addr.size();
    issue_cmd(1'b0, 32'h0000_0200, 3);
    check("rstreq:valid_before", bus.reg_req.valid, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstreq:valid_dropped", bus.reg_req.valid, 0);
    check("rstreq:cmd_ready", bus.cmd_ready, 1);
    check("rstreq:busy", bus.busy, 0);
    check("rstreq:err", bus.err, 0);
    rst_n     = 1'b1;
    rsp_never = 1'b0;
    n_valid   = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.reg_req.valid) n_valid++;
    end
    check("rstreq:no_replay", n_valid, 0);
    check("rstreq:no_tx", obs_addr.size() - base, 0);

    for (int n = 0; n < 8; n++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = (n == 3) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      r_len   = $urandom_range(1, 6);
      r_lat   = $urandom_range(0, 3);
      r_stall = $urandom_range(0, 3);
      r_ek    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_len - 1) : 99;
      run_burst($sformatf("rnd%0d", n), r_wr, r_addr, r_len, r_lat, r_stall, r_ek);
    end

    rsp_never = 1'b1;
    base      = obs_addr.size();
    issue_cmd(1'b0, 32'h0000_0300, 2);
`ifdef KECCAK_REG_INITIATOR_TIMEOUT_EN
    n_valid = 0;
    for (k = 0; k < 100; k++) begin
      if (bus.err) break;
      if (bus.reg_req.valid) n_valid++;
      @(negedge clk);
    end
    check("to:err_set", bus.err, 1);
    check("to:req_cycles", n_valid, 16);
    check("to:done", bus.done, 1);
    check("to:valid_dropped", bus.reg_req.valid, 0);
    @(negedge clk);
    check("to:idle", bus.cmd_ready, 1);
`else
    k = 0;
    repeat (1000) @(negedge clk);
    check("noto:still_valid", bus.reg_req.valid, 1);
    check("noto:busy", bus.busy, 1);
    check("noto:no_err", bus.err, 0);
    check("noto:no_done", bus.done, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("noto:recover_idle", bus.cmd_ready, 1);
`endif
    check("to:no_tx", obs_addr.size() - base, 0);
    rsp_never = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
